// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: operand stream, accumulator drive and result port of the MAC sequencer.
interface mac_sequencer_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_a;
    logic [3:0]    in_b;
    logic          in_last;
    logic [3:0]    mac_a;
    logic [3:0]    mac_b;
    logic          mac_clken;
    logic          mac_clear;
    logic [7:0]    mac_result;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_result;
    logic [AW:0]   out_count;
    logic          busy;
    modport slave (
        input  in_valid, in_a, in_b, in_last, mac_result, out_ready,
        output in_ready, mac_a, mac_b, mac_clken, mac_clear, out_valid, out_result, out_count, busy
    );
    modport master (
        output in_valid, in_a, in_b, in_last, mac_result, out_ready,
        input  in_ready, mac_a, mac_b, mac_clken, mac_clear, out_valid, out_result, out_count, busy
    );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: buffers one operand vector, feeds it to the accumulator every other cycle, flushes and returns the dot product.
module mac_sequencer #(
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    mac_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {LOAD, ISSUE, GAP, FLUSH, FLUSH_GAP, HOLD} state_t;
    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_buf [DEPTH];
    logic [AW-1:0] r_wr_idx;
    logic [AW-1:0] r_rd_idx;
    logic [AW:0]   r_count;
    logic [AW:0]   r_out_count;
    logic [7:0]    r_out_result;
    logic [7:0]    w_pair;
    logic          w_accept;
    logic          w_close;
    logic          w_last_rd;
    assign w_accept  = (r_state == LOAD) && bus.in_valid;
    // A full buffer closes the vector regardless of in_last
    assign w_close   = bus.in_last || (r_count == (AW+1)'(DEPTH - 1));
    assign w_last_rd = ({1'b0, r_rd_idx} + (AW+1)'(1)) == r_count;
    assign w_pair    = r_buf[r_rd_idx];
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= LOAD;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            LOAD:      w_next = (w_accept && w_close) ? ISSUE : LOAD;
            ISSUE:     w_next = GAP;
            GAP:       w_next = w_last_rd ? FLUSH : ISSUE;
            FLUSH:     w_next = FLUSH_GAP;
            FLUSH_GAP: w_next = HOLD;
            HOLD:      w_next = bus.out_ready ? LOAD : HOLD;
            default:   w_next = LOAD;
        endcase
    end
    always_ff @(posedge clk) begin
        if (w_accept)
            r_buf[r_wr_idx] <= {bus.in_a, bus.in_b};
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_idx     <= '0;
            r_rd_idx     <= '0;
            r_count      <= '0;
            r_out_result <= '0;
            r_out_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_idx <= r_wr_idx + AW'(1);
                r_count  <= r_count + (AW+1)'(1);
                r_rd_idx <= '0;
            end
            if (r_state == GAP && !w_last_rd)
                r_rd_idx <= r_rd_idx + AW'(1);
            if (r_state == FLUSH_GAP) begin
                r_out_result <= bus.mac_result;
                r_out_count  <= r_count;
            end
            if (r_state == HOLD && bus.out_ready) begin
                r_wr_idx <= '0;
                r_count  <= '0;
            end
        end
    end
    assign bus.in_ready   = r_state == LOAD;
    assign bus.mac_clken  = (r_state == ISSUE) || (r_state == FLUSH);
    assign bus.mac_a      = (r_state == ISSUE) ? w_pair[7:4] : 4'd0;
    assign bus.mac_b      = (r_state == ISSUE) ? w_pair[3:0] : 4'd0;
    assign bus.mac_clear  = (r_state == ISSUE) && (r_rd_idx == '0);
    assign bus.out_valid  = r_state == HOLD;
    assign bus.out_result = r_out_result;
    assign bus.out_count  = r_out_count;
    assign bus.busy       = r_state != LOAD;
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: table-driven and random vectors against a behavioural accumulator and dot-product model.
module tb_mac_sequencer;
    localparam int DEPTH = 16;
    typedef struct {
        int               n;
        bit               use_last;
        logic [15:0][3:0] a;
        logic [15:0][3:0] b;
        int               hold;
        logic [7:0]       exp_res;
    } vec_t;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] acc = 8'd0;
    logic [7:0] held_prod = 8'd0;
    logic       held_clear = 1'b0;
    vec_t       tbl [6];
    vec_t       rv;
    bit         ok;
    int         s;
    mac_sequencer_if #(.DEPTH(DEPTH)) bus ();
    mac_sequencer #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );
    always #5 clk = ~clk;
    // Accumulator: a pair issued now is added on the following issue edge
    assign bus.mac_result = acc;
    always @(posedge clk) begin
        if (bus.mac_clken) begin
            acc        <= (held_clear ? 8'd0 : acc) + held_prod;
            held_prod  <= 8'(bus.mac_a) * 8'(bus.mac_b);
            held_clear <= bus.mac_clear;
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    task automatic load_pairs(input vec_t v);
        int k;
        for (int i = 0; i < v.n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = v.a[i];
            bus.in_b     = v.b[i];
            bus.in_last  = v.use_last && (i == v.n - 1);
            k = 0;
            while (!bus.in_ready && k < 50) begin
                tick;
                k++;
            end
            check("in_ready_load", int'(bus.in_ready), 1);
            tick;
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            if (i < v.n - 1 && $urandom_range(3) == 0)
                tick;
        end
    endtask
    task automatic run_vec(input vec_t v);
        bit         good;
        bit         issue;
        logic [3:0] ea;
        logic [3:0] eb;
        load_pairs(v);
        good = 1'b1;
        for (int i = 0; i < 2 * v.n + 2; i++) begin
            issue = (i % 2 == 0) && (i < 2 * v.n);
            ea = issue ? v.a[i / 2] : 4'd0;
            eb = issue ? v.b[i / 2] : 4'd0;
            if (bus.mac_clken !== (i % 2 == 0) || bus.mac_clear !== (i == 0) ||
                bus.mac_a !== ea || bus.mac_b !== eb || bus.in_ready !== 1'b0 ||
                bus.out_valid !== 1'b0 || bus.busy !== 1'b1)
                good = 1'b0;
            tick;
        end
        check("issue_pattern", int'(good), 1);
        check("out_valid_latency", int'(bus.out_valid), 1);
        good = 1'b1;
        for (int i = 0; i < v.hold; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out_result !== v.exp_res || bus.out_count !== 5'(v.n) ||
                bus.in_ready !== 1'b0 || bus.mac_clken !== 1'b0)
                good = 1'b0;
            tick;
        end
        check("hold_stable", int'(good), 1);
        check("out_result", int'(bus.out_result), int'(v.exp_res));
        check("out_count", int'(bus.out_count), v.n);
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        check("out_valid_drop", int'(bus.out_valid), 0);
        check("in_ready_after", int'(bus.in_ready), 1);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = 4'd0;
        bus.in_b      = 4'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        reset_n = 1'b0;
        tick;
        tick;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_result", int'(bus.out_result), 0);
        check("rst_out_count", int'(bus.out_count), 0);
        check("rst_mac_a", int'(bus.mac_a), 0);
        check("rst_mac_b", int'(bus.mac_b), 0);
        check("rst_mac_clken", int'(bus.mac_clken), 0);
        check("rst_mac_clear", int'(bus.mac_clear), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        reset_n = 1'b1;
        tick;
        for (int i = 0; i < 6; i++) begin
            tbl[i].a = '0;
            tbl[i].b = '0;
            tbl[i].use_last = 1'b1;
            tbl[i].hold = 0;
        end
        tbl[0].n = 3;  tbl[0].exp_res = 8'd33;
        tbl[0].a[0] = 4'd2; tbl[0].a[1] = 4'd4; tbl[0].a[2] = 4'd1;
        tbl[0].b[0] = 4'd3; tbl[0].b[1] = 4'd5; tbl[0].b[2] = 4'd7;
        tbl[1].n = 16; tbl[1].exp_res = 8'd16; tbl[1].hold = 1;
        tbl[1].a = {16{4'd15}}; tbl[1].b = {16{4'd15}};
        tbl[2].n = 16; tbl[2].exp_res = 8'd16; tbl[2].use_last = 1'b0;
        tbl[2].a = {16{4'd1}}; tbl[2].b = {16{4'd1}};
        tbl[3].n = 1;  tbl[3].exp_res = 8'd9;
        tbl[3].a[0] = 4'd3; tbl[3].b[0] = 4'd3;
        tbl[4].n = 1;  tbl[4].exp_res = 8'd2;
        tbl[4].a[0] = 4'd1; tbl[4].b[0] = 4'd2;
        tbl[5].n = 2;  tbl[5].exp_res = 8'd114; tbl[5].hold = 5;
        tbl[5].a[0] = 4'd6; tbl[5].a[1] = 4'd8;
        tbl[5].b[0] = 4'd7; tbl[5].b[1] = 4'd9;
        for (int i = 0; i < 6; i++)
            run_vec(tbl[i]);
        rv.a = '0;
        rv.b = '0;
        rv.n = 2;
        rv.use_last = 1'b1;
        rv.hold = 0;
        rv.a[0] = 4'd5; rv.a[1] = 4'd5; rv.b[0] = 4'd5; rv.b[1] = 4'd5;
        load_pairs(rv);
        tick;
        tick;
        tick;
        check("gap_clken", int'(bus.mac_clken), 0);
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_mac_clken", int'(bus.mac_clken), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        check("midrst_out_result", int'(bus.out_result), 0);
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid !== 1'b0 || bus.mac_clken !== 1'b0)
                ok = 1'b0;
            tick;
        end
        check("midrst_no_result", int'(ok), 1);
        rv.n = 1;
        rv.a = '0;
        rv.b = '0;
        rv.a[0] = 4'd2;
        rv.b[0] = 4'd2;
        rv.exp_res = 8'd4;
        run_vec(rv);
        for (int t = 0; t < 20; t++) begin
            rv.n = int'($urandom_range(1, 16));
            rv.use_last = (rv.n < 16) ? 1'b1 : 1'($urandom_range(1));
            rv.hold = int'($urandom_range(3));
            rv.a = '0;
            rv.b = '0;
            s = 0;
            for (int i = 0; i < rv.n; i++) begin
                rv.a[i] = 4'($urandom);
                rv.b[i] = 4'($urandom);
                s += int'(rv.a[i]) * int'(rv.b[i]);
            end
            rv.exp_res = 8'(s);
            run_vec(rv);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
